// File: rtl/sev_seg_pkg.sv
// Shared types and defaults for the two-digit seven-segment scan controller.
package sev_seg_pkg;

    // Scan phases, visited in declaration order and then wrapping.
    typedef enum logic [1:0] {
        BLANK1 = 2'd0,
        SHOW1  = 2'd1,
        BLANK2 = 2'd2,
        SHOW2  = 2'd3
    } scan_state_e;

    localparam int DEFAULT_DWELL_CYCLES = 24000;
    localparam int DEFAULT_BLANK_CYCLES = 480;

    function automatic logic is_show(input scan_state_e s);
        return (s == SHOW1) || (s == SHOW2);
    endfunction

endpackage

// File: rtl/sev_seg_dwell_timer.sv
// Phase counter: counts up from 0 and flags the last cycle of a phase of
// length len. The owner pulses restart on that cycle to start the next phase.
module sev_seg_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         restart,
    input  logic [W-1:0] len,
    output logic         done,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: wrap to 0 at a phase boundary, otherwise increment.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the
        // variable unassigned, which would infer a latch.
        count_d = count_q + W'(1);
        if (restart) begin
            count_d = '0;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from
        // the values present before the edge, independent of statement order.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done  = (count_q == len - W'(1));
    assign count = count_q;

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Time-multiplexed driver for two seven-segment displays sharing one decoder.
// Each frame blanks, shows digit 1, blanks, shows digit 2. Digit, enable and
// brightness are sampled on entry to each show phase; brightness limits how
// many quarters of the show phase the anode stays lit. All outputs decode
// registered state only.
module sev_seg_scan_ctrl
    import sev_seg_pkg::*;
#(
    parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [1:0] en,
    input  logic [1:0] bright,
    output logic       seg1sel,
    output logic       seg2sel,
    output logic [3:0] sw,
    output logic       frame_tick
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int QUARTER = DWELL_CYCLES / 4;

    scan_state_e      state_q, state_d;
    logic [3:0]       sw_q, sw_d;
    logic             en_q, en_d;
    logic [1:0]       bright_q, bright_d;
    logic [CNT_W-1:0] phase_len;
    logic [CNT_W-1:0] phase_count;
    logic [CNT_W-1:0] lit_limit;
    logic             phase_done;
    logic             lit;

    assign phase_len = is_show(state_q) ? CNT_W'(DWELL_CYCLES) : CNT_W'(BLANK_CYCLES);

    sev_seg_dwell_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .restart(phase_done),
        .len    (phase_len),
        .done   (phase_done),
        .count  (phase_count)
    );

    // Phase sequencing; shadow registers load on the edge entering a show phase.
    always_comb begin
        state_d  = state_q;
        sw_d     = sw_q;
        en_d     = en_q;
        bright_d = bright_q;
        if (phase_done) begin
            case (state_q)
                BLANK1: begin
                    state_d  = SHOW1;
                    sw_d     = digit1;
                    en_d     = en[0];
                    bright_d = bright;
                end
                SHOW1:  state_d = BLANK2;
                BLANK2: begin
                    state_d  = SHOW2;
                    sw_d     = digit2;
                    en_d     = en[1];
                    bright_d = bright;
                end
                SHOW2:   state_d = BLANK1;
                default: state_d = BLANK1;
            endcase
        end
    end

    // State and shadow registers; reset aborts any phase in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BLANK1;
            sw_q     <= 4'h0;
            en_q     <= 1'b0;
            bright_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            sw_q     <= sw_d;
            en_q     <= en_d;
            bright_q <= bright_d;
        end
    end

    // Lit window length: (bright+1) quarters of the show phase.
    always_comb begin
        case (bright_q)
            2'd0:    lit_limit = CNT_W'(QUARTER);
            2'd1:    lit_limit = CNT_W'(2 * QUARTER);
            2'd2:    lit_limit = CNT_W'(3 * QUARTER);
            default: lit_limit = CNT_W'(4 * QUARTER);
        endcase
    end

    assign lit        = en_q && (phase_count < lit_limit);
    assign seg1sel    = (state_q == SHOW1) && lit;
    assign seg2sel    = (state_q == SHOW2) && lit;
    assign sw         = sw_q;
    assign frame_tick = (state_q == SHOW2) && phase_done;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Scoreboard bench for sev_seg_scan_ctrl with DWELL_CYCLES=8, BLANK_CYCLES=2.
// A frame-position model pushes the expected outputs for each cycle as the
// stimulus for that cycle is applied; scenario tasks pop and compare.
module tb_sev_seg_scan_ctrl;

    localparam int DW    = 8;
    localparam int BW    = 2;
    localparam int FRAME = 2 * (DW + BW);
    localparam int S1_LO = BW;
    localparam int S1_HI = BW + DW - 1;
    localparam int S2_LO = 2 * BW + DW;
    localparam int S2_HI = FRAME - 1;

    typedef struct packed {
        logic       s1;
        logic       s2;
        logic [3:0] sw;
        logic       tick;
    } out_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digit1 = 4'h0;
    logic [3:0] digit2 = 4'h0;
    logic [1:0] en = 2'b00;
    logic [1:0] bright = 2'd0;
    logic       seg1sel, seg2sel, frame_tick;
    logic [3:0] sw;

    out_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // Model state: position of the observed cycle within the frame (0-based),
    // cycle number since the last reset edge (1-based), captured values.
    int         m_pos = 0;
    int         cyc = 0;
    logic [3:0] m_sw = 4'h0;
    logic       m_en = 1'b0;
    logic [1:0] m_br = 2'd0;

    sev_seg_scan_ctrl #(
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .digit1    (digit1),
        .digit2    (digit2),
        .en        (en),
        .bright    (bright),
        .seg1sel   (seg1sel),
        .seg2sel   (seg2sel),
        .sw        (sw),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic string fmt(input out_t v);
        return $sformatf("s1=%b s2=%b sw=%h tick=%b", v.s1, v.s2, v.sw, v.tick);
    endfunction

    // Apply one clock edge with the current inputs: push the model's
    // expectation for the following cycle, then sample the DUT.
    task automatic advance(output out_t obs);
        out_t e;
        int   lim;
        if (reset) begin
            m_pos = 0;
            cyc   = 1;
            m_sw  = 4'h0;
            m_en  = 1'b0;
            m_br  = 2'd0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
            cyc++;
            if (m_pos == S1_LO) begin
                m_sw = digit1; m_en = en[0]; m_br = bright;
            end else if (m_pos == S2_LO) begin
                m_sw = digit2; m_en = en[1]; m_br = bright;
            end
        end
        lim    = (int'(m_br) + 1) * DW / 4;
        e.s1   = (m_pos >= S1_LO) && (m_pos <= S1_HI) && m_en && ((m_pos - S1_LO) < lim);
        e.s2   = (m_pos >= S2_LO) && (m_pos <= S2_HI) && m_en && ((m_pos - S2_LO) < lim);
        e.sw   = m_sw;
        e.tick = (m_pos == S2_HI);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs = '{s1: seg1sel, s2: seg2sel, sw: sw, tick: frame_tick};
    endtask

    // One reset edge, then release; leaves the bench observing cycle 1.
    task automatic restart_dut(input string name);
        out_t o, e;
        reset = 1'b1;
        advance(o);
        e = exp_q.pop_front();
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL %s reset cyc=%0d got %s want %s", name, cyc, fmt(o), fmt(e));
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        out_t o, e;
        int first1 = 0, last1 = 0, first2 = 0, last2 = 0, tick_at = 0;
        digit1 = 4'h1; digit2 = 4'h2; en = 2'b11; bright = 2'd3;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance(o);
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL reset_hold cyc=%0d got %s want %s", cyc, fmt(o), fmt(e));
            end
        end
        reset = 1'b0;
        for (int i = 1; i < FRAME; i++) begin
            advance(o);
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL reset_frame cyc=%0d got %s want %s", cyc, fmt(o), fmt(e));
            end
            if (o.s1) begin if (first1 == 0) first1 = cyc; last1 = cyc; end
            if (o.s2) begin if (first2 == 0) first2 = cyc; last2 = cyc; end
            if (o.tick) tick_at = cyc;
        end
        tests_run++;
        if (first1 !== 3 || last1 !== 10) begin
            tests_failed++;
            $display("FAIL reset_seg1_window got %0d..%0d want 3..10", first1, last1);
        end
        tests_run++;
        if (first2 !== 13 || last2 !== 20) begin
            tests_failed++;
            $display("FAIL reset_seg2_window got %0d..%0d want 13..20", first2, last2);
        end
        tests_run++;
        if (tick_at !== 20) begin
            tests_failed++;
            $display("FAIL reset_tick_cycle got %0d want 20", tick_at);
        end
    endtask

    // Two full frames from reset with fixed inputs; checks every cycle plus
    // lit-cycle counts, select exclusivity, sw/select pairing and tick period.
    task automatic run_frames(input string name, input logic [3:0] d1, input logic [3:0] d2,
                              input logic [1:0] en_v, input logic [1:0] br_v,
                              input int want1, input int want2);
        out_t o, e;
        int n1 = 0, n2 = 0, both = 0, bad_sw = 0, ticks = 0, tick1 = 0, tick2 = 0;
        digit1 = d1; digit2 = d2; en = en_v; bright = br_v;
        restart_dut(name);
        for (int i = 1; i < 2 * FRAME; i++) begin
            advance(o);
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL %s cyc=%0d got %s want %s", name, cyc, fmt(o), fmt(e));
            end
            if (o.s1) n1++;
            if (o.s2) n2++;
            if (o.s1 && o.s2) both++;
            if ((o.s1 && o.sw !== d1) || (o.s2 && o.sw !== d2)) bad_sw++;
            if (o.tick) begin
                ticks++;
                if (tick1 == 0) tick1 = cyc; else tick2 = cyc;
            end
        end
        tests_run++;
        if (n1 !== 2 * want1 || n2 !== 2 * want2) begin
            tests_failed++;
            $display("FAIL %s lit_count got %0d/%0d want %0d/%0d", name, n1, n2, 2 * want1, 2 * want2);
        end
        tests_run++;
        if (both !== 0 || bad_sw !== 0) begin
            tests_failed++;
            $display("FAIL %s overlap_or_sw got both=%0d bad_sw=%0d want 0/0", name, both, bad_sw);
        end
        tests_run++;
        if (ticks !== 2 || tick2 - tick1 !== FRAME) begin
            tests_failed++;
            $display("FAIL %s tick_period got n=%0d period=%0d want 2/%0d", name, ticks, tick2 - tick1, FRAME);
        end
    endtask

    task automatic test_values();
        run_frames("values", 4'hA, 4'h5, 2'b11, 2'd3, 8, 8);
    endtask

    task automatic test_brightness();
        run_frames("bright1", 4'h6, 4'h9, 2'b11, 2'd1, 4, 4);
        run_frames("bright0", 4'hC, 4'h3, 2'b11, 2'd0, 2, 2);
        run_frames("bright2", 4'hF, 4'h0, 2'b11, 2'd2, 6, 6);
    endtask

    task automatic test_enable();
        run_frames("enable10", 4'hB, 4'hE, 2'b10, 2'd3, 0, 8);
        run_frames("enable01", 4'h2, 4'h8, 2'b01, 2'd3, 8, 0);
    endtask

    task automatic test_midphase();
        out_t o, e;
        digit1 = 4'h3; digit2 = 4'hD; en = 2'b11; bright = 2'd3;
        restart_dut("midphase");
        while (cyc < 2 * FRAME) begin
            advance(o);
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL midphase cyc=%0d got %s want %s", cyc, fmt(o), fmt(e));
            end
            if (cyc == 6) begin
                digit1 = 4'h7;
                bright = 2'd0;
            end
            if (cyc == 10) begin
                tests_run++;
                if (o.sw !== 4'h3 || o.s1 !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL midphase_hold got sw=%h s1=%b want sw=3 s1=1", o.sw, o.s1);
                end
            end
            if (cyc == FRAME + 3) begin
                tests_run++;
                if (o.sw !== 4'h7) begin
                    tests_failed++;
                    $display("FAIL midphase_update got sw=%h want 7", o.sw);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        out_t o, e;
        digit1 = 4'h4; digit2 = 4'h9; en = 2'b11; bright = 2'd3;
        restart_dut("reset_mid");
        while (cyc < 17) begin
            advance(o);
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL reset_mid_run cyc=%0d got %s want %s", cyc, fmt(o), fmt(e));
            end
        end
        tests_run++;
        if (o.s2 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_pre got s2=%b want 1", o.s2);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance(o);
            e = exp_q.pop_front();
            reset = 1'b0;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL reset_mid_after cyc=%0d got %s want %s", cyc, fmt(o), fmt(e));
            end
        end
        tests_run++;
        if (o.s1 !== 1'b1 || cyc !== 3) begin
            tests_failed++;
            $display("FAIL reset_mid_blank got s1=%b at cyc=%0d want 1 at 3", o.s1, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_values();
        test_brightness();
        test_enable();
        test_midphase();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
